// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button inputs and conditioned level/pulse outputs
interface button_conditioner_if;
  logic iBtnIzq;
  logic iBtnDer;
  logic oIzqNivel;
  logic oDerNivel;
  logic oPulsoIzq;
  logic oPulsoDer;
  logic oConflicto;

  modport master (
    output iBtnIzq, iBtnDer,
    input  oIzqNivel, oDerNivel, oPulsoIzq, oPulsoDer, oConflicto
  );

  modport slave (
    input  iBtnIzq, iBtnDer,
    output oIzqNivel, oDerNivel, oPulsoIzq, oPulsoDer, oConflicto
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-channel button synchronizer, debouncer and move-pulse generator
// Auto-repeat is built in only when BTN_AUTOREPEAT_EN is defined; otherwise one pulse per press.
module button_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int REP_DELAY  = 64,
  parameter int REP_PERIOD = 16,
  parameter int CNT_W      = 16
) (
  input  logic                 iClk,
  input  logic                 iReset,
  button_conditioner_if.slave  btn
);

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, PRESS, DELAY, REPEAT} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;
  logic unused_rep_cfg;
  assign unused_rep_cfg = (REP_DELAY > 0) ^ (REP_PERIOD > 0);
`endif

  // Channel 0 is left (Izq), channel 1 is right (Der).
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] level_v;
  logic [1:0] level_nxt_v;
  logic [1:0] pulse_v;
  logic       conflict;

  assign raw = {btn.iBtnDer, btn.iBtnIzq};

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      sync1    <= '0;
      sync2    <= '0;
      conflict <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      conflict <= level_nxt_v[0] & level_nxt_v[1];
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             level;
    logic             level_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    state_t           state;
    state_t           state_nxt;
    logic             pulse;
`ifdef BTN_AUTOREPEAT_EN
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
`endif

    always_comb begin
      level_nxt = level;
      cnt_nxt   = '0;
      if (sync2[ch] != level) begin
        if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
          level_nxt = ~level;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    end

    // A low level overrides every state, so no pulse leaks out on release.
    always_comb begin
      state_nxt = state;
      pulse     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      timer_nxt = '0;
`endif
      if (!level) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: state_nxt = PRESS;
`ifdef BTN_AUTOREPEAT_EN
          PRESS: begin
            pulse     = 1'b1;
            state_nxt = DELAY;
            timer_nxt = CNT_W'(1);
          end
          DELAY: begin
            if (timer >= CNT_W'(REP_DELAY - 1)) begin
              state_nxt = REPEAT;
            end else begin
              timer_nxt = timer + CNT_W'(1);
            end
          end
          REPEAT: begin
            pulse = (timer == '0);
            if (timer < CNT_W'(REP_PERIOD - 1)) begin
              timer_nxt = timer + CNT_W'(1);
            end
          end
`else
          PRESS: begin
            pulse     = 1'b1;
            state_nxt = HOLD;
          end
          HOLD: state_nxt = HOLD;
`endif
          default: state_nxt = IDLE;
        endcase
      end
    end

    always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
        level <= 1'b0;
        cnt   <= '0;
        state <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
        timer <= '0;
`endif
      end else begin
        level <= level_nxt;
        cnt   <= cnt_nxt;
        state <= state_nxt;
`ifdef BTN_AUTOREPEAT_EN
        timer <= timer_nxt;
`endif
      end
    end

    assign level_v[ch]     = level;
    assign level_nxt_v[ch] = level_nxt;
    assign pulse_v[ch]     = pulse;
  end

  // A move request while the opposite button is down is swallowed; timers keep running.
  assign btn.oIzqNivel  = level_v[0];
  assign btn.oDerNivel  = level_v[1];
  assign btn.oPulsoIzq  = pulse_v[0] & ~level_v[1];
  assign btn.oPulsoDer  = pulse_v[1] & ~level_v[0];
  assign btn.oConflicto = conflict;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and random checks of button_conditioner against a behavioural model
module tb_button_conditioner;
  localparam int DEB  = 4;
  localparam int RDLY = 8;
  localparam int RPER = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt_pi  = 0;
  int   cnt_pd  = 0;

  button_conditioner_if btn ();

  button_conditioner #(
    .DEB_CYCLES(DEB), .REP_DELAY(RDLY), .REP_PERIOD(RPER), .CNT_W(8)
  ) dut (
    .iClk(clk), .iReset(rst), .btn(btn)
  );

  always #5 clk = ~clk;

  // Model: input seen two edges late, level flips after DEB straight disagreeing cycles,
  // pulses placed by the number of cycles since the level rose.
  bit cur[2];
  bit d1[2];
  bit d2[2];
  bit m_lvl[2];
  int run[2];
  int age[2];

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      d1[ch] = 0; d2[ch] = 0; m_lvl[ch] = 0; run[ch] = 0; age[ch] = 0;
    end
  endtask

  task automatic model_edge();
    for (int ch = 0; ch < 2; ch++) begin
      bit was;
      was = m_lvl[ch];
      if (d2[ch] != m_lvl[ch]) begin
        run[ch] = run[ch] + 1;
        if (run[ch] == DEB) begin
          m_lvl[ch] = !m_lvl[ch];
          run[ch] = 0;
        end
      end else begin
        run[ch] = 0;
      end
      if (m_lvl[ch] && was) age[ch] = age[ch] + 1;
      else age[ch] = 0;
      d2[ch] = d1[ch];
      d1[ch] = cur[ch];
    end
  endtask

  function automatic bit exp_pulse(int ch);
    int t;
    if (!m_lvl[ch] || age[ch] < 1) return 1'b0;
    t = age[ch] - 1;
`ifdef BTN_AUTOREPEAT_EN
    return (t == 0) || (t >= RDLY && ((t - RDLY) % RPER) == 0);
`else
    return t == 0;
`endif
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_izq_nivel"}, btn.oIzqNivel, 1'b0);
    check({tag, "_der_nivel"}, btn.oDerNivel, 1'b0);
    check({tag, "_pulso_izq"}, btn.oPulsoIzq, 1'b0);
    check({tag, "_pulso_der"}, btn.oPulsoDer, 1'b0);
    check({tag, "_conflicto"}, btn.oConflicto, 1'b0);
  endtask

  task automatic step(input bit izq, input bit der);
    btn.iBtnIzq = izq;
    btn.iBtnDer = der;
    cur[0] = izq;
    cur[1] = der;
    @(negedge clk);
    check("izq_nivel", btn.oIzqNivel, m_lvl[0]);
    check("der_nivel", btn.oDerNivel, m_lvl[1]);
    check("pulso_izq", btn.oPulsoIzq, exp_pulse(0) & !m_lvl[1]);
    check("pulso_der", btn.oPulsoDer, exp_pulse(1) & !m_lvl[0]);
    check("conflicto", btn.oConflicto, m_lvl[0] & m_lvl[1]);
    if (btn.oPulsoIzq === 1'b1) cnt_pi++;
    if (btn.oPulsoDer === 1'b1) cnt_pd++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic repeat_step(input int n, input bit izq, input bit der);
    for (int i = 0; i < n; i++) step(izq, der);
  endtask

  initial begin
    btn.iBtnIzq = 1'b0;
    btn.iBtnDer = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // short glitch never reaches the level
    repeat_step(3, 1, 0);
    repeat_step(12, 0, 0);

    // left held 30 cycles
    cnt_pi = 0;
    repeat_step(30, 1, 0);
    repeat_step(15, 0, 0);
`ifdef BTN_AUTOREPEAT_EN
    check_int("izq_press_pulses", cnt_pi, 7);
`else
    check_int("izq_press_pulses", cnt_pi, 1);
`endif

    // right held 30 cycles
    cnt_pd = 0;
    repeat_step(30, 0, 1);
    repeat_step(15, 0, 0);
`ifdef BTN_AUTOREPEAT_EN
    check_int("der_press_pulses", cnt_pd, 7);
`else
    check_int("der_press_pulses", cnt_pd, 1);
`endif

    // both held: conflict, every pulse masked
    cnt_pi = 0;
    cnt_pd = 0;
    repeat_step(25, 1, 1);
    repeat_step(12, 0, 0);
    check_int("conflict_pulses_izq", cnt_pi, 0);
    check_int("conflict_pulses_der", cnt_pd, 0);

    // reset mid-cycle while held, then fresh debounce
    repeat_step(20, 1, 0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cnt_pi = 0;
    repeat_step(7, 1, 0);
    check_int("no_pulse_before_fresh_press", cnt_pi, 0);
    repeat_step(18, 1, 0);
    repeat_step(12, 0, 0);

    // random segments with glitches of all lengths
    for (int seg = 0; seg < 80; seg++) begin
      bit izq;
      bit der;
      int len;
      izq = 1'($urandom_range(0, 1));
      der = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      len = int'($urandom_range(1, 30));
      repeat_step(len, izq, der);
    end
    repeat_step(12, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 16, meaning consecutive cycles a synchronized input must differ from the stable level before the stable level updates.
REQ-002 The module SHALL have parameter REP_DELAY, default 64, meaning cycles from the first move pulse to the first auto-repeat pulse.
REP-003 The module SHALL have parameter REP_PERIOD, default 16, meaning cycles between successive auto-repeat pulses.
REQ-004 The module SHALL have parameter CNT_W, default 16, meaning the width of all internal counters (values above 2^CNT_W-1 are illegal).
REQ-005 The module SHALL have port iClk, input, 1, meaning the single clock; all logic SHALL be on its rising edge.
REQ-006 The module SHALL have port iReset, input, 1, meaning reset, asynchronous, active-high.
REQ-007 The module SHALL have port iBtnIzq, input, 1, meaning raw asynchronous left button, active-high.
REQ-008 The module SHALL have port iBtnDer, input, 1, meaning raw asynchronous right button, active-high.
REQ-009 The module SHALL have port oIzqNivel, output, 1, meaning the debounced left level.
REQ-010 The module SHALL have port oDerNivel, output, 1, meaning the debounced right level.
REQ-011 The module SHALL have port oPulsoIzq, output, 1, meaning a one-cycle left move request to the player FSM.
REQ-012 The module SHALL have port oPulsoDer, output, 1, meaning a one-cycle right move request to the player FSM.
REQ-013 The module SHALL have port oConflicto, output, 1, meaning both debounced levels are high.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Debounce: a per-channel counter SHALL increment while the synchronized value differs from the stable level, SHALL clear on any cycle it matches, and the stable level SHALL toggle (with the counter cleared) when the count reaches DEB_CYCLES.
REQ-016 Glitches shorter than DEB_CYCLES cycles SHALL never change oIzqNivel or oDerNivel.
REQ-017 Timing: with raw input high from cycle 0 (set just after edge 0), the level SHALL rise in cycle 2+DEB_CYCLES and the first pulse SHALL be asserted in cycle 3+DEB_CYCLES.
REQ-018 Each channel SHALL have an FSM with states IDLE, PRESS, DELAY, REPEAT.
REQ-019 FSM transitions: IDLE->PRESS on a level rise; PRESS SHALL last one cycle, assert the pulse, and go to DELAY.
REQ-020 FSM DELAY: the FSM SHALL count REP_DELAY cycles from the PRESS pulse, then assert the pulse and go to REPEAT.
REQ-021 FSM REPEAT: the FSM SHALL assert the pulse every REP_PERIOD cycles.
REQ-022 In any state, level low SHALL force IDLE next cycle with no pulse and cleared timers.
REQ-023 oConflicto SHALL equal oIzqNivel AND oDerNivel, registered, with the same timing as the levels.
REQ-024 Any pulse falling in a cycle where the other channel's level is high SHALL be masked to 0, while both FSMs keep timing.
REQ-025 A pulse SHALL never be wider than one cycle, and both pulses SHALL never be high together.

Reset
REQ-026 While iReset is high, all outputs, synchronizers, counters and stable levels SHALL be 0 and both FSMs SHALL be in IDLE, immediately and without waiting for a clock.
REQ-027 After release, a held button SHALL require a full fresh debounce before its level or a pulse appears; reset mid-repeat SHALL emit no pulse.

Configuration
REQ-028 Macro BTN_AUTOREPEAT_EN SHALL control the auto-repeat feature: when defined, REQ-020/REQ-021 behaviour SHALL apply.
REQ-029 When BTN_AUTOREPEAT_EN is undefined, PRESS SHALL go to a HOLD state that emits no pulses until the level drops, the DELAY/REPEAT logic and counters SHALL be absent, and exactly one pulse SHALL occur per press.

Verification (DEB_CYCLES=4, REP_DELAY=8, REP_PERIOD=4)
REQ-030 Reset asserted mid-cycle with the button held -> all outputs 0 asynchronously, before the next edge.
REQ-031 iBtnIzq high for 3 cycles then low -> oIzqNivel and oPulsoIzq stay 0 throughout.
REQ-032 iBtnIzq high from cycle 0, macro undefined -> oIzqNivel rises in cycle 6; a single oPulsoIzq occurs in cycle 7 only.
REQ-033 iBtnDer held 0..29, macro defined -> oPulsoDer in cycles 7, 15, 19, 23, 27, 31, 35; none after oDerNivel falls in cycle 36.
REQ-034 Both buttons high from cycle 0 -> oConflicto is 1 from cycle 6, and both pulse outputs stay 0.
REQ-035 Reset pulse at cycle 20 of a held press, macro defined -> no pulse until cycle 20+release+7, after which the sequence restarts.
